// File: rtl/doc_mbox_pkg.sv
// doc_mbox_pkg: command/error codes, header layout and FSM states shared by the DOC mailbox responder.
package doc_mbox_pkg;
   localparam logic [10:0] CMD_GET_VOLTAGE     = 11'h018;
   localparam logic [10:0] CMD_GET_TEMPERATURE = 11'h019;
   localparam logic [10:0] ERR_OK   = 11'd0;
   localparam logic [10:0] ERR_LEN  = 11'd1;
   localparam logic [10:0] ERR_OVF  = 11'd2;
   localparam logic [10:0] ERR_UNK  = 11'd3;
   localparam logic [10:0] ERR_MASK = 11'd4;
   localparam logic [10:0] ERR_INJ  = 11'd7;
   localparam int HDR_ID_LSB   = 24;
   localparam int HDR_LEN_LSB  = 12;
   localparam int HDR_CODE_LSB = 0;
   typedef enum logic [2:0] {IDLE, CMD_ARGS, DRAIN, EXEC, RSP_HDR, RSP_DATA} state_t;
   typedef struct packed {
      logic [3:0]  rsvd_hi;
      logic [3:0]  id;
      logic        rsvd_len;
      logic [10:0] len;
      logic        rsvd_code;
      logic [10:0] code;
   } hdr_t;
   function automatic logic [31:0] mk_hdr(input logic [3:0] id, input logic [10:0] len, input logic [10:0] code);
      hdr_t h;
      h      = '0;
      h.id   = id;
      h.len  = len;
      h.code = code;
      return h;
   endfunction
endpackage

// File: rtl/doc_mbox_rsp_sel.sv
// doc_mbox_rsp_sel: lowest set channel of the remaining response mask, and whether it is the last one.
module doc_mbox_rsp_sel (
   input  logic [31:0] mask,
   output logic [4:0]  idx,
   output logic        last
);
   always_comb begin
      idx = '0;
      for (int i = 31; i >= 0; i--) if (mask[i]) idx = 5'(i);
      last = (mask & (mask - 32'd1)) == '0;
   end
endmodule

// File: rtl/doc_mailbox_responder.sv
// doc_mailbox_responder: Avalon-ST mailbox responder serving GET_VOLTAGE/GET_TEMPERATURE.
// Defining DOC_MBOX_FAULT_INJ_EN adds fault_inj_err/fault_inj_flip for forced errors and data corruption.
module doc_mailbox_responder import doc_mbox_pkg::*; #(
   parameter int P_NO_CHANNELS      = 4,
   parameter int P_NO_TEMP_CHANNELS = 4,
   parameter int P_RSP_LATENCY      = 8,
   parameter int P_MAX_ARGS         = 4
) (
   input  logic                            hw_clk,
   input  logic                            hw_reset_n,
   output logic                            command_ready,
   input  logic                            command_valid,
   input  logic [31:0]                     command_data,
   input  logic                            command_startofpacket,
   input  logic                            command_endofpacket,
   input  logic                            response_ready,
   output logic                            response_valid,
   output logic [31:0]                     response_data,
   output logic                            response_startofpacket,
   output logic                            response_endofpacket,
   input  logic [P_NO_CHANNELS*32-1:0]      voltage_sample,
   input  logic [P_NO_TEMP_CHANNELS*32-1:0] temperature_sample,
`ifdef DOC_MBOX_FAULT_INJ_EN
   input  logic                            fault_inj_err,
   input  logic [31:0]                     fault_inj_flip,
`endif
   output logic                            busy
);
   localparam logic [10:0] MAX_ARGS = 11'(P_MAX_ARGS);
   localparam logic [7:0]  LAT_LOAD = 8'(P_RSP_LATENCY - 1);

   state_t        state;
   logic [3:0]    id_q;
   logic [10:0]   len_q, code_q, arg_cnt, err_c, len_c;
   logic [31:0]   mask_q, mask_rem, flip;
   logic [7:0]    lat;
   logic [1023:0] smp_q;
   logic [4:0]    idx;
   logic          ovf_q, inj_q, inj_in, inj_now, is_volt, known, in_range, last, cmd_xfer, rsp_xfer;

`ifdef DOC_MBOX_FAULT_INJ_EN
   assign inj_in = fault_inj_err;
   assign flip   = fault_inj_flip;
`else
   assign inj_in = 1'b0;
   assign flip   = '0;
`endif

   assign busy     = state != IDLE;
   assign cmd_xfer = command_valid & command_ready;
   assign rsp_xfer = response_valid & response_ready;
   assign is_volt  = code_q == CMD_GET_VOLTAGE;
   assign known    = is_volt || code_q == CMD_GET_TEMPERATURE;
   assign in_range = is_volt ? (mask_q >> P_NO_CHANNELS) == '0 : (mask_q >> P_NO_TEMP_CHANNELS) == '0;
   assign inj_now  = inj_q | inj_in;
   assign err_c    = inj_now ? ERR_INJ : ovf_q ? ERR_OVF : !known ? ERR_UNK :
                     arg_cnt != len_q ? ERR_LEN : (mask_q == '0 || !in_range) ? ERR_MASK : ERR_OK;
   assign len_c    = err_c == ERR_OK ? 11'($countones(mask_q)) : '0;

   doc_mbox_rsp_sel u_sel (.mask(mask_rem), .idx(idx), .last(last));

   always_ff @(posedge hw_clk or negedge hw_reset_n) begin
      if (!hw_reset_n) begin
         state                  <= IDLE;
         command_ready          <= 1'b0;
         response_valid         <= 1'b0;
         response_data          <= '0;
         response_startofpacket <= 1'b0;
         response_endofpacket   <= 1'b0;
         id_q                   <= '0;
         len_q                  <= '0;
         code_q                 <= '0;
         arg_cnt                <= '0;
         mask_q                 <= '0;
         mask_rem               <= '0;
         lat                    <= '0;
         smp_q                  <= '0;
         ovf_q                  <= 1'b0;
         inj_q                  <= 1'b0;
      end else begin
         case (state)
            IDLE, CMD_ARGS, DRAIN: begin
               command_ready <= 1'b1;
               if (cmd_xfer) begin
                  if (command_startofpacket && state != DRAIN) begin
                     id_q    <= command_data[HDR_ID_LSB +: 4];
                     len_q   <= command_data[HDR_LEN_LSB +: 11];
                     code_q  <= command_data[HDR_CODE_LSB +: 11];
                     arg_cnt <= '0;
                     mask_q  <= '0;
                     ovf_q   <= 1'b0;
                     inj_q   <= 1'b0;
                  end else if (state == CMD_ARGS) begin
                     if (arg_cnt == '0) mask_q <= command_data;
                     if (arg_cnt == MAX_ARGS) ovf_q <= 1'b1;
                     if (arg_cnt != '1) arg_cnt <= arg_cnt + 11'd1;
                  end
                  // IDLE only leaves on a header word; stray words are dropped here
                  if (state != IDLE || command_startofpacket) begin
                     if (command_endofpacket) begin
                        state         <= EXEC;
                        command_ready <= 1'b0;
                        lat           <= LAT_LOAD;
                     end else if (state == CMD_ARGS && !command_startofpacket && arg_cnt == MAX_ARGS) state <= DRAIN;
                     else if (state == IDLE) state <= CMD_ARGS;
                  end
               end
            end
            EXEC: begin
               inj_q <= inj_now;
               if (lat == '0) begin
                  state                  <= RSP_HDR;
                  smp_q                  <= is_volt ? 1024'(voltage_sample) : 1024'(temperature_sample);
                  mask_rem               <= err_c == ERR_OK ? mask_q : '0;
                  response_valid         <= 1'b1;
                  response_startofpacket <= 1'b1;
                  response_endofpacket   <= len_c == '0;
                  response_data          <= mk_hdr(id_q, len_c, err_c);
               end else lat <= lat - 8'd1;
            end
            RSP_HDR, RSP_DATA: begin
               if (rsp_xfer) begin
                  if (response_endofpacket) begin
                     state                  <= IDLE;
                     command_ready          <= 1'b1;
                     response_valid         <= 1'b0;
                     response_startofpacket <= 1'b0;
                     response_endofpacket   <= 1'b0;
                  end else begin
                     state                  <= RSP_DATA;
                     response_startofpacket <= 1'b0;
                     response_endofpacket   <= last;
                     response_data          <= smp_q[{idx, 5'd0} +: 32] ^ flip;
                     mask_rem               <= mask_rem & ~(32'd1 << idx);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_doc_mailbox_responder.sv
// tb_doc_mailbox_responder: randomized and directed checks of doc_mailbox_responder against a packet-level model.
module tb_doc_mailbox_responder;
   localparam int NV = 4, NT = 4, LAT = 8, MAXA = 4;

   logic            hw_clk = 1'b0, hw_reset_n = 1'b0;
   logic            command_ready, command_valid = 1'b0, command_startofpacket = 1'b0, command_endofpacket = 1'b0;
   logic [31:0]     command_data = '0;
   logic            response_ready = 1'b0, response_valid, response_startofpacket, response_endofpacket, busy;
   logic [31:0]     response_data;
   logic [NV*32-1:0] voltage_sample = '0;
   logic [NT*32-1:0] temperature_sample = '0;
`ifdef DOC_MBOX_FAULT_INJ_EN
   logic            fault_inj_err = 1'b0;
   logic [31:0]     fault_inj_flip = '0;
`endif

   int checks = 0, failures = 0;
   logic [31:0] pkt_q[$], exp_q[$];

   always #5 hw_clk = ~hw_clk;

   doc_mailbox_responder #(.P_NO_CHANNELS(NV), .P_NO_TEMP_CHANNELS(NT), .P_RSP_LATENCY(LAT), .P_MAX_ARGS(MAXA)) dut (
      .hw_clk(hw_clk), .hw_reset_n(hw_reset_n),
      .command_ready(command_ready), .command_valid(command_valid), .command_data(command_data),
      .command_startofpacket(command_startofpacket), .command_endofpacket(command_endofpacket),
      .response_ready(response_ready), .response_valid(response_valid), .response_data(response_data),
      .response_startofpacket(response_startofpacket), .response_endofpacket(response_endofpacket),
      .voltage_sample(voltage_sample), .temperature_sample(temperature_sample),
`ifdef DOC_MBOX_FAULT_INJ_EN
      .fault_inj_err(fault_inj_err), .fault_inj_flip(fault_inj_flip),
`endif
      .busy(busy));

   task automatic randomize_samples();
      for (int i = 0; i < NV; i++) voltage_sample[i*32 +: 32] = $urandom;
      for (int i = 0; i < NT; i++) temperature_sample[i*32 +: 32] = $urandom;
   endtask

   // Packet-level reference: derive the whole expected response from the command words
   task automatic build_model(input logic [31:0] flip_m, input logic inj_m);
      logic [31:0] h, mask;
      logic [10:0] code;
      int nargs, nch, len, err, cnt;
      exp_q.delete();
      h     = pkt_q[0];
      code  = h[10:0];
      len   = int'(h[22:12]);
      nargs = pkt_q.size() - 1;
      mask  = nargs > 0 ? pkt_q[1] : 32'd0;
      nch   = code == 11'h018 ? NV : NT;
      if (inj_m) err = 7;
      else if (nargs > MAXA) err = 2;
      else if (code != 11'h018 && code != 11'h019) err = 3;
      else if (nargs != len) err = 1;
      else if (mask == 0 || (mask >> nch) != 0) err = 4;
      else err = 0;
      if (err != 0) exp_q.push_back({4'h0, h[27:24], 24'(err)});
      else begin
         cnt = $countones(mask);
         exp_q.push_back({4'h0, h[27:24], 1'b0, 11'(cnt), 12'h000});
         for (int ch = 0; ch < 32; ch++)
            if (mask[ch]) exp_q.push_back((code == 11'h018 ? voltage_sample[ch*32 +: 32] : temperature_sample[ch*32 +: 32]) ^ flip_m);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input logic s, input logic e);
      int n = 0;
      command_valid = 1'b1; command_data = w; command_startofpacket = s; command_endofpacket = e;
      @(negedge hw_clk);
      while (!command_ready && n < 200) begin @(negedge hw_clk); n++; end
      if (!command_ready) begin checks++; failures++; $display("FAIL cmd_ready_timeout got=0 exp=1"); end
      @(posedge hw_clk); #1;
      command_valid = 1'b0; command_startofpacket = 1'b0; command_endofpacket = 1'b0;
   endtask

   task automatic send_pkt();
      for (int i = 0; i < pkt_q.size(); i++) send_word(pkt_q[i], i == 0, i == pkt_q.size() - 1);
   endtask

   // mode 0: always ready, 1: toggling ready, 2: random ready
   task automatic collect(input string nm, input int mode, output int first_n);
      logic [31:0] got[$];
      logic [31:0] prev_d;
      logic prev_stall = 1'b0, done = 1'b0;
      int n = 0;
      first_n = -1;
      while (!done && n < 600) begin
         @(negedge hw_clk); n++;
         response_ready = mode == 0 ? 1'b1 : mode == 1 ? n[0] : 1'($urandom_range(0, 1));
         if (prev_stall) begin
            checks++;
            if (response_valid !== 1'b1 || response_data !== prev_d) begin
               failures++; $display("FAIL %s stall_hold got=%b/%h exp=1/%h", nm, response_valid, response_data, prev_d);
            end
         end
         if (response_valid === 1'b1) begin
            if (first_n < 0) first_n = n;
            if (response_ready) begin
               checks++;
               if ({response_startofpacket, response_endofpacket} !== {got.size() == 0, got.size() == exp_q.size() - 1}) begin
                  failures++; $display("FAIL %s framing word%0d got=%b%b exp=%b%b", nm, got.size(), response_startofpacket,
                     response_endofpacket, got.size() == 0, got.size() == exp_q.size() - 1);
               end
               got.push_back(response_data);
               if (response_endofpacket) done = 1'b1;
            end
            prev_stall = !response_ready;
            prev_d     = response_data;
         end else prev_stall = 1'b0;
      end
      checks++;
      if (!done) begin failures++; $display("FAIL %s rsp_timeout got=%0d words exp=%0d", nm, got.size(), exp_q.size()); end
      else begin
         @(posedge hw_clk); #1;
         if (command_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL %s ready_after_rsp got=%b/%b exp=1/0", nm, command_ready, busy);
         end
      end
      checks++;
      if (got.size() != exp_q.size()) begin failures++; $display("FAIL %s word_count got=%0d exp=%0d", nm, got.size(), exp_q.size()); end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin failures++; $display("FAIL %s word%0d got=%h exp=%h", nm, i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge hw_clk);
      checks++;
      if ({command_ready, response_valid, response_startofpacket, response_endofpacket, busy} !== 5'b0 || response_data !== 32'h0) begin
         failures++; $display("FAIL reset_outputs got=%b%b%b%b%b/%h exp=00000/00000000", command_ready, response_valid,
            response_startofpacket, response_endofpacket, busy, response_data);
      end
      hw_reset_n = 1'b1;
      @(negedge hw_clk);
      checks++;
      if (command_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", command_ready); end
   endtask

   task automatic test_voltage_read();
      int fn;
      randomize_samples();
      pkt_q = '{32'h0000_1018, 32'h5};
      exp_q = '{32'h0000_2000, voltage_sample[31:0], voltage_sample[95:64]};
      send_pkt();
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL volt_busy got=%b exp=1", busy); end
      collect("volt_read", 0, fn);
      checks++;
      if (fn != LAT + 1) begin failures++; $display("FAIL volt_latency got=%0d exp=%0d", fn - 1, LAT); end
   endtask

   task automatic test_backpressure();
      int fn;
      randomize_samples();
      pkt_q = '{32'h0000_1018, 32'h5};
      exp_q = '{32'h0000_2000, voltage_sample[31:0], voltage_sample[95:64]};
      send_pkt();
      collect("backpressure", 1, fn);
   endtask

   task automatic test_unknown();
      int fn;
      pkt_q = '{32'h0000_0055};
      exp_q = '{32'h0000_0003};
      send_pkt();
      collect("unknown_code", 0, fn);
   endtask

   task automatic test_errors();
      int fn;
      pkt_q = '{32'h0000_4018, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
      exp_q = '{32'h0000_0002};
      for (int i = 0; i < pkt_q.size(); i++) begin
         send_word(pkt_q[i], i == 0, i == pkt_q.size() - 1);
         if (i < pkt_q.size() - 1) begin
            checks++;
            if (response_valid !== 1'b0) begin failures++; $display("FAIL ovf_early_rsp word%0d got=%b exp=0", i, response_valid); end
         end
      end
      collect("overflow", 0, fn);
      pkt_q = '{32'h0000_2018, 32'h1};
      exp_q = '{32'h0000_0001};
      send_pkt(); collect("length_err", 2, fn);
      pkt_q = '{32'h0000_1019, 32'h10};
      exp_q = '{32'h0000_0004};
      send_pkt(); collect("mask_range", 0, fn);
      randomize_samples();
      pkt_q = '{32'h0300_4019, 32'hF, 32'h0, 32'h0, 32'h0};
      exp_q = '{32'h0300_4000, temperature_sample[31:0], temperature_sample[63:32], temperature_sample[95:64], temperature_sample[127:96]};
      send_pkt(); collect("max_args_ok", 2, fn);
   endtask

   task automatic test_reset_mid();
      int n = 0, stale = 0;
      pkt_q = '{32'h0000_1018, 32'hF};
      send_pkt();
      response_ready = 1'b1;
      while (!(response_valid === 1'b1 && response_startofpacket === 1'b0) && n < 100) begin @(negedge hw_clk); n++; end
      response_ready = 1'b0;
      checks++;
      if (n >= 100) begin failures++; $display("FAIL reset_mid_reach_data got=timeout exp=rsp_data"); end
      @(negedge hw_clk);
      hw_reset_n = 1'b0;
      #1;
      checks++;
      if ({response_valid, busy, command_ready} !== 3'b000) begin
         failures++; $display("FAIL reset_mid_async got=%b%b%b exp=000", response_valid, busy, command_ready);
      end
      @(negedge hw_clk);
      hw_reset_n = 1'b1;
      response_ready = 1'b1;
      @(negedge hw_clk);
      checks++;
      if (command_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_ready got=%b exp=1", command_ready); end
      repeat (20) begin @(negedge hw_clk); if (response_valid !== 1'b0) stale++; end
      checks++;
      if (stale != 0) begin failures++; $display("FAIL reset_mid_stale got=%0d exp=0", stale); end
   endtask

   task automatic test_back_to_back();
      int fn;
      for (int k = 0; k < 3; k++) begin
         randomize_samples();
         pkt_q = '{{8'h0, 4'(k), 20'h0_1018}, 32'h8 >> k};
         build_model(32'h0, 1'b0);
         send_pkt();
         collect("back_to_back", 0, fn);
      end
   endtask

   task automatic test_random();
      int fn, nargs;
      logic [3:0] id;
      logic [10:0] code, len;
      logic [31:0] mask;
      for (int it = 0; it < 40; it++) begin
         int sel;
         randomize_samples();
         id    = 4'($urandom_range(0, 15));
         sel   = $urandom_range(0, 9);
         code  = sel < 4 ? 11'h018 : sel < 8 ? 11'h019 : 11'($urandom_range(0, 2047));
         nargs = $urandom_range(0, 6);
         len   = $urandom_range(0, 3) == 0 ? 11'($urandom_range(0, 7)) : 11'(nargs);
         mask  = $urandom_range(0, 7) == 0 ? 32'($urandom) : 32'($urandom_range(1, 15));
         pkt_q = '{{4'h0, id, 1'b0, len, 1'b0, code}};
         for (int a = 0; a < nargs; a++) pkt_q.push_back(a == 0 ? mask : 32'($urandom));
         build_model(32'h0, 1'b0);
         send_pkt();
         collect("random", $urandom_range(0, 2), fn);
      end
   endtask

`ifdef DOC_MBOX_FAULT_INJ_EN
   task automatic test_fault_inj();
      int fn;
      randomize_samples();
      temperature_sample[63:32] = 32'h0000_002A;
      fault_inj_flip = 32'hFFFF_FFFF;
      pkt_q = '{32'h0000_1019, 32'h2};
      exp_q = '{32'h0000_1000, 32'hFFFF_FFD5};
      send_pkt(); collect("fault_flip", 0, fn);
      fault_inj_flip = '0;
      fault_inj_err  = 1'b1;
      pkt_q = '{32'h0000_1019, 32'h2};
      exp_q = '{32'h0000_0007};
      send_pkt(); collect("fault_err", 0, fn);
      fault_inj_err = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_voltage_read();
      test_backpressure();
      test_unknown();
      test_errors();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef DOC_MBOX_FAULT_INJ_EN
      test_fault_inj();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
